// File: rtl/vram_mirror_ctrl.sv
// vram_mirror_ctrl: nametable VRAM with run-time mirroring, registered reads and a hardware fill engine
module vram_mirror_ctrl #(
    parameter int DATA_WIDTH      = 8,
    parameter int PAGE_ADDR_WIDTH = 10,
    parameter int NUM_PAGES       = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       en_in,
    input  logic                       r_nw_in,
    input  logic [PAGE_ADDR_WIDTH+1:0] a_in,
    input  logic [DATA_WIDTH-1:0]      d_in,
    output logic [DATA_WIDTH-1:0]      d_out,
    output logic                       rd_vld_out,
    input  logic [2:0]                 mirror_in,
    input  logic                       clr_start_in,
    input  logic [DATA_WIDTH-1:0]      clr_val_in,
    output logic                       busy_out,
    output logic                       done_out
);
    localparam int PAGE_BITS = (NUM_PAGES == 4) ? 2 : 1;
    localparam int PHYS_AW   = PAGE_ADDR_WIDTH + PAGE_BITS;
    localparam int DEPTH     = 1 << PHYS_AW;
    localparam logic [PHYS_AW:0] CNT_LAST = (PHYS_AW + 1)'(DEPTH - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t                r_state;
    logic [PHYS_AW:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_clr_val;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [1:0]            w_nt;
    logic [1:0]            w_sel;
    logic [PAGE_BITS-1:0]  w_page;
    logic [PHYS_AW-1:0]    w_phys;
    logic [PHYS_AW-1:0]    w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_idle;
    logic                  w_we;

    // Four-screen only exists with four physical pages; every unlisted mode falls back to vertical
    always_comb begin
        w_nt    = a_in[PAGE_ADDR_WIDTH +: 2];
        w_sel   = mirror_in == 3'd0 ? {1'b0, w_nt[1]} :
                  mirror_in == 3'd2 ? 2'd0 :
                  mirror_in == 3'd3 ? 2'd1 :
                  (mirror_in == 3'd4 && NUM_PAGES == 4) ? w_nt : {1'b0, w_nt[0]};
        w_page  = PAGE_BITS'(w_sel);
        w_phys  = {w_page, a_in[PAGE_ADDR_WIDTH-1:0]};
        w_idle  = r_state == IDLE;
        w_we    = w_idle ? (en_in && r_nw_in && !clr_start_in) : 1'b1;
        w_waddr = w_idle ? w_phys : r_cnt[PHYS_AW-1:0];
        w_wdata = w_idle ? d_in : r_clr_val;
    end

    always_ff @(posedge clk_in) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_clr_val  <= '0;
            d_out      <= '0;
            rd_vld_out <= 1'b0;
            busy_out   <= 1'b0;
            done_out   <= 1'b0;
        end else begin
            rd_vld_out <= 1'b0;
            done_out   <= 1'b0;
            if (r_state == IDLE) begin
                if (clr_start_in) begin
                    r_state   <= FILL;
                    r_clr_val <= clr_val_in;
                    r_cnt     <= '0;
                    busy_out  <= 1'b1;
                end else if (en_in && !r_nw_in) begin
                    d_out      <= r_mem[w_phys];
                    rd_vld_out <= 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) begin
                    r_state  <= IDLE;
                    busy_out <= 1'b0;
                    done_out <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vram_mirror_ctrl.sv
// tb_vram_mirror_ctrl: 2-page and 4-page instances on shared stimulus, checked against an array model
module tb_vram_mirror_ctrl;
    logic        clk = 0, rst_n = 0, en = 0, r_nw = 0, clr_start = 0;
    logic [11:0] a = 0;
    logic [7:0]  d = 0, clr_val = 0;
    logic [2:0]  mirror = 0;
    logic [7:0]  d2, d4;
    logic        v2, v4, b2, b4, dn2, dn4;
    int          total = 0, bad = 0;

    bit [7:0] mm [2][4096];
    bit       busy_m [2], done_m [2], vld_m [2];
    bit [7:0] dout_m [2], val_m [2];
    int       cnt_m [2];

    vram_mirror_ctrl #(.DATA_WIDTH(8), .PAGE_ADDR_WIDTH(10), .NUM_PAGES(2)) u2 (
        .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .r_nw_in(r_nw), .a_in(a), .d_in(d),
        .d_out(d2), .rd_vld_out(v2), .mirror_in(mirror), .clr_start_in(clr_start),
        .clr_val_in(clr_val), .busy_out(b2), .done_out(dn2));
    vram_mirror_ctrl #(.DATA_WIDTH(8), .PAGE_ADDR_WIDTH(10), .NUM_PAGES(4)) u4 (
        .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .r_nw_in(r_nw), .a_in(a), .d_in(d),
        .d_out(d4), .rd_vld_out(v4), .mirror_in(mirror), .clr_start_in(clr_start),
        .clr_val_in(clr_val), .busy_out(b4), .done_out(dn4));

    always #5 clk = ~clk;

    function automatic int phys(int np, int mode, int addr);
        int nt, page;
        nt = addr / 1024;
        page = mode == 0 ? nt / 2 : mode == 2 ? 0 : mode == 3 ? 1 :
               (mode == 4 && np == 4) ? nt : nt % 2;
        return page * 1024 + addr % 1024;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                busy_m[i] = 0; done_m[i] = 0; vld_m[i] = 0; dout_m[i] = 0; cnt_m[i] = 0;
            end else begin
                done_m[i] = 0;
                vld_m[i]  = 0;
                if (busy_m[i]) begin
                    mm[i][cnt_m[i]] = val_m[i];
                    cnt_m[i]++;
                    if (cnt_m[i] == (i + 1) * 2048) begin
                        busy_m[i] = 0;
                        done_m[i] = 1;
                    end
                end else if (clr_start) begin
                    busy_m[i] = 1; val_m[i] = clr_val; cnt_m[i] = 0;
                end else if (en) begin
                    if (r_nw) mm[i][phys((i + 1) * 2, int'(mirror), int'(a))] = d;
                    else begin
                        dout_m[i] = mm[i][phys((i + 1) * 2, int'(mirror), int'(a))];
                        vld_m[i]  = 1;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("d_out2", d2, dout_m[0]);    chk("d_out4", d4, dout_m[1]);
        chk("rd_vld2", v2, vld_m[0]);    chk("rd_vld4", v4, vld_m[1]);
        chk("busy2", b2, busy_m[0]);     chk("busy4", b4, busy_m[1]);
        chk("done2", dn2, done_m[0]);    chk("done4", dn4, done_m[1]);
    end

    task automatic wr(input logic [11:0] addr, input logic [7:0] val);
        @(negedge clk);
        en = 1; r_nw = 1; a = addr; d = val;
        @(negedge clk);
        en = 0;
    endtask

    task automatic rd(input logic [11:0] addr, output logic [7:0] r2, output logic [7:0] r4);
        @(negedge clk);
        en = 1; r_nw = 0; a = addr;
        @(negedge clk);
        en = 0;
        r2 = d2; r4 = d4;
        chk("rd_vld2_lit", v2, 1);
        chk("rd_vld4_lit", v4, 1);
    endtask

    task automatic fill(input logic [7:0] val, input bit hold, input bit inject, input int stop_at);
        int n2 = 0, n4 = 0, guard = 0;
        @(negedge clk);
        clr_start = 1; clr_val = val;
        @(negedge clk);
        if (!hold) clr_start = 0;
        while ((b2 || b4) && guard < 10000) begin
            if (b2) n2++;
            if (b4) n4++;
            if (inject && n2 == 10) begin en = 1; r_nw = 1; a = 12'h010; d = 8'hFF; end
            else if (inject && n2 == 11) begin en = 1; r_nw = 0; end
            else en = 0;
            if (inject && n2 == 12) chk("fill_rd_vld_lit", v2, 0);
            if (stop_at > 0 && n2 == stop_at) begin
                clr_start = 0;
                rst_n = 0;
                #1;
                chk("rst_busy2_lit", b2, 0);
                chk("rst_busy4_lit", b4, 0);
                @(negedge clk);
                rst_n = 1;
                return;
            end
            @(negedge clk);
            guard++;
            if (!b2) clr_start = 0;
        end
        en = 0;
        chk("fill_timeout", guard < 10000, 1);
        chk("fill_len2", n2, 2048);
        chk("fill_len4", n4, 4096);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] r2, r4, q2, q4;
        int guard;
        repeat (3) @(negedge clk);
        chk("reset_d_out_lit", d2, 0);
        chk("reset_busy_lit", b4, 0);
        rst_n = 1;
        fill(8'h24, 1, 1, 0);
        mirror = 3'd1;
        rd(12'h010, r2, r4);
        chk("fill_drop_wr2", r2, 8'h24); chk("fill_drop_wr4", r4, 8'h24);
        mirror = 3'd4;
        for (int i = 0; i < 4096; i++) begin
            rd(i[11:0], r2, r4);
            chk("fill_all2", r2, 8'h24);
            chk("fill_all4", r4, 8'h24);
        end
        mirror = 3'd1;
        wr(12'h000, 8'h5A); wr(12'h400, 8'h11);
        rd(12'h800, r2, r4);
        chk("vert_nt2_2", r2, 8'h5A); chk("vert_nt2_4", r4, 8'h5A);
        rd(12'h400, r2, r4);
        chk("vert_nt1_2", r2, 8'h11); chk("vert_nt1_4", r4, 8'h11);
        mirror = 3'd0;
        wr(12'h005, 8'hC3); wr(12'h805, 8'h77);
        rd(12'h405, r2, r4);
        chk("horz_nt1", r2, 8'hC3); chk("horz_nt1_4", r4, 8'hC3);
        rd(12'h805, r2, r4);
        chk("horz_nt2", r2, 8'h77); chk("horz_nt2_4", r4, 8'h77);
        mirror = 3'd3;
        rd(12'h005, r2, r4);
        rd(12'hC05, q2, q4);
        chk("ssb_nt0", r2, 8'h77); chk("ssb_nt3", q2, 8'h77); chk("ssb_nt3_4", q4, 8'h77);
        mirror = 3'd4;
        for (int i = 0; i < 4; i++) wr(12'(i * 1024), 8'(i + 1));
        for (int i = 0; i < 4; i++) begin
            rd(12'(i * 1024), r2, r4);
            chk("four_scr4", r4, i + 1);
            chk("four_scr2", r2, (i % 2) + 3);
        end
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            en = 1'($urandom_range(0, 1)); r_nw = 1'($urandom_range(0, 1));
            a = 12'($urandom); d = 8'($urandom); mirror = 3'($urandom_range(0, 7));
            clr_start = $urandom_range(0, 999) == 0; clr_val = 8'($urandom);
        end
        @(negedge clk);
        en = 0; clr_start = 0;
        guard = 0;
        while ((b2 || b4) && guard < 10000) begin
            @(negedge clk);
            guard++;
        end
        chk("idle_timeout", guard < 10000, 1);
        mirror = 3'd1;
        wr(12'h7FF, 8'h66); wr(12'h000, 8'h33);
        fill(8'h24, 0, 0, 100);
        repeat (2) @(negedge clk);
        rd(12'h000, r2, r4);
        chk("part_fill_a0_2", r2, 8'h24); chk("part_fill_a0_4", r4, 8'h24);
        rd(12'h7FF, r2, r4);
        chk("part_fill_7ff_2", r2, 8'h66); chk("part_fill_7ff_4", r4, 8'h66);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vram_mirror_ctrl.md
Name: vram_mirror_ctrl

Overview:
Parametrised successor to the on-board nametable VRAM. It wraps a synchronous block RAM of NUM_PAGES pages and maps the PPU's 4-page logical nametable space onto physical pages through a run-time mirroring mode. It adds a registered read-valid strobe and a hardware fill/clear engine used by the mapper and debug logic at power-up and on mapper switch. It sits between the PPU VRAM bus and the cartridge mirroring control.

Parameters:
DATA_WIDTH, 8, width of one VRAM word.
PAGE_ADDR_WIDTH, 10, address bits within one nametable page (1 KB page at default).
NUM_PAGES, 2, physical pages implemented; legal values 2 or 4. PHYS_AW = PAGE_ADDR_WIDTH + log2(NUM_PAGES); DEPTH = 2^PHYS_AW.

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
en_in  input  1  chip enable for a PPU access
r_nw_in  input  1  0 = read, 1 = write
a_in  input  PAGE_ADDR_WIDTH+2  logical address; top 2 bits select logical nametable NT0..NT3
d_in  input  DATA_WIDTH  write data
d_out  output  DATA_WIDTH  registered read data
rd_vld_out  output  1  one-cycle strobe: d_out updated this cycle
mirror_in  input  3  mirroring mode
clr_start_in  input  1  start fill engine (sampled in IDLE only)
clr_val_in  input  DATA_WIDTH  fill value, latched on accepted start
busy_out  output  1  fill engine active
done_out  output  1  one-cycle pulse on fill completion

Behaviour:
- Interface: one clock, clk_in; reset rst_n_in is asynchronous and active-low.
- Reset values: d_out=0, rd_vld_out=0, busy_out=0, done_out=0, FSM=IDLE, fill counter=0. RAM contents are not reset.
- Page mapping is combinational per access, with nt = a_in[top 2 bits]:
  - mirror_in 0 (horizontal): page = nt[1].
  - 1 (vertical): page = nt[0].
  - 2 (single-screen A): page = 0.
  - 3 (single-screen B): page = 1.
  - 4 (four-screen): page = nt when NUM_PAGES=4; treated as vertical when NUM_PAGES=2.
  - 5-7: treated as vertical.
  - Physical address = {page, a_in[PAGE_ADDR_WIDTH-1:0]}; upper page bit is 0 when NUM_PAGES=2.
- Write: en_in=1 and r_nw_in=1 in IDLE writes d_in at the sampling edge.
- Read: en_in=1 and r_nw_in=0 in IDLE.
  - Latency 1: d_out and rd_vld_out=1 valid after the next edge.
  - d_out holds its last value until the next read; it is not zeroed when en_in=0.
  - A read following a write to the same address returns the new data.
- Mode change: mirror_in may change between any two accesses. No state depends on it.
- Fill FSM has states IDLE and FILL.
  - IDLE -> FILL when clr_start_in=1 at edge k. At that edge: latch clr_val_in, counter=0, busy_out=1.
  - FILL writes the latched value to physical address = counter on edges k+1..k+DEPTH, incrementing counter each edge.
  - On the edge that writes address DEPTH-1 (edge k+DEPTH): FSM goes to IDLE, busy_out=0, done_out=1 for exactly one cycle.
  - The fill ignores mirroring and covers all physical words.
- While busy_out=1:
  - PPU accesses (en_in=1) are dropped: no write occurs, rd_vld_out stays 0, d_out is unchanged.
  - clr_start_in is ignored.
- clr_start_in and en_in asserted together in IDLE: the fill is accepted and the PPU access is dropped.
- Reset asserted mid-fill: immediate return to IDLE with busy_out=0 and no done_out. RAM is left partially filled.
- Counter width is PHYS_AW+1 and does not wrap during FILL.

Test Plan:
- NUM_PAGES=2, mirror_in=1: write 0x5A to a_in=0x000, then read a_in=0x800 -> rd_vld_out=1 one cycle later, d_out=0x5A. Read 0x400 -> not 0x5A (0x400 pre-written with 0x11 reads 0x11).
- mirror_in=0: write 0xC3 at 0x005, read 0x405 -> 0xC3; read 0x805 -> its distinct pre-written value. mirror_in=3: reads of 0x005 and 0xC05 return the same word.
- NUM_PAGES=4, mirror_in=4: write 0x01..0x04 to 0x000/0x400/0x800/0xC00, read back -> four distinct values. Same stimulus with NUM_PAGES=2 -> NT0=NT2 and NT1=NT3.
- Fill with clr_val_in=0x24 at edge k (DEPTH=2048): busy_out high for 2048 cycles; done_out pulses after edge k+2048; every address read afterwards returns 0x24.
- During fill, issue a write of 0xFF to 0x010 and a read: no rd_vld_out, d_out unchanged; after done, 0x010 reads 0x24. clr_start_in held high during fill -> no restart (busy_out falls exactly at k+2048).
- Assert rst_n_in at fill cycle 100 -> busy_out=0 immediately, done_out never pulses; address 0 reads 0x24, address 0x7FF reads its old value.
